// File: rtl/err_inj_sequencer.sv
// Error-injection sequencer: drives one-hot err_ctrl / err_en at the root of the
// splitter tree. It runs either a single-site or a sweep campaign of timed windows.
module err_inj_sequencer #(
   parameter int CTRLW = 8,
   parameter int SITEW = 3,
   parameter int HOLDW = 8,
   parameter int GAPW  = 8,
   parameter int CNTW  = 8
) (
   input  logic             clk,
   input  logic             rst_l,
   input  logic             start,
   input  logic             sweep,
   input  logic [SITEW-1:0] site_idx,
   input  logic [HOLDW-1:0] hold_cycles,
   input  logic [GAPW-1:0]  gap_cycles,
   input  logic             abort,
   output logic             err_en,
   output logic [CTRLW-1:0] err_ctrl,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic [SITEW-1:0] cur_site,
   output logic [CNTW-1:0]  inj_count
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ARM    = 3'd1;
   localparam logic [2:0] S_INJECT = 3'd2;
   localparam logic [2:0] S_GAP    = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   localparam int TW = (HOLDW > GAPW) ? HOLDW : GAPW;
   localparam logic [SITEW-1:0] LAST_SITE = SITEW'(CTRLW - 1);

   logic [2:0]       state;
   logic [TW-1:0]    timer;
   logic             sweep_q;
   logic [HOLDW-1:0] hold_q;
   logic [GAPW-1:0]  gap_q;
   logic [TW-1:0]    hold_load;
   logic [TW-1:0]    gap_load;
   logic             site_ok;
   logic             timer_last;

   // A zero count is treated as one cycle so every window and gap is observable.
   always_comb begin
      hold_load  = (hold_q == '0) ? TW'(1) : TW'(hold_q);
      gap_load   = (gap_q == '0) ? TW'(1) : TW'(gap_q);
      site_ok    = (int'(site_idx) < CTRLW);
      timer_last = (timer <= TW'(1));
   end

   always_ff @(posedge clk) begin
      if (!rst_l) begin
         state     <= S_IDLE;
         timer     <= '0;
         sweep_q   <= 1'b0;
         hold_q    <= '0;
         gap_q     <= '0;
         aborted   <= 1'b0;
         cur_site  <= '0;
         inj_count <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  sweep_q   <= sweep;
                  hold_q    <= hold_cycles;
                  gap_q     <= gap_cycles;
                  inj_count <= '0;
                  cur_site  <= site_idx;
                  aborted   <= !site_ok;
                  state     <= site_ok ? S_ARM : S_DONE;
               end
            end
            S_ARM: begin
               if (abort) begin
                  aborted <= 1'b1;
                  state   <= S_DONE;
               end else begin
                  timer <= hold_load;
                  state <= S_INJECT;
               end
            end
            S_INJECT: begin
               // Abort wins over a window ending in the same cycle: it does not count.
               if (abort) begin
                  aborted <= 1'b1;
                  state   <= S_DONE;
               end else if (timer_last) begin
                  if (inj_count != '1)
                     inj_count <= inj_count + 1'b1;
                  timer <= gap_load;
                  state <= S_GAP;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            S_GAP: begin
               if (abort) begin
                  aborted <= 1'b1;
                  state   <= S_DONE;
               end else if (timer_last) begin
                  if (!sweep_q || cur_site == LAST_SITE) begin
                     state <= S_DONE;
                  end else begin
                     cur_site <= cur_site + 1'b1;
                     state    <= S_ARM;
                  end
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      busy   = (state != S_IDLE);
      done   = (state == S_DONE);
      err_en = (state == S_INJECT);
      err_ctrl = '0;
      for (int unsigned i = 0; i < CTRLW; i++)
         err_ctrl[i] = ((state == S_ARM) || (state == S_INJECT)) && (cur_site == SITEW'(i));
   end

endmodule
